// File: rtl/chu_chasing_led_pkg.sv
// Shared register offsets, CTRL bit positions and FSM states for the chasing-LED slot core.
package chu_chasing_led_pkg;

    localparam logic [4:0] REG_CTRL   = 5'd0;
    localparam logic [4:0] REG_PERIOD = 5'd1;
    localparam logic [4:0] REG_STEPS  = 5'd2;
    localparam logic [4:0] REG_STAT   = 5'd3;
    localparam logic [4:0] REG_IRQ    = 5'd4;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_WRAP = 1;
    localparam int CTRL_CLR  = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2
    } state_t;

endpackage

// File: rtl/chu_tick_gen.sv
// Step-rate prescaler: pulses tick once every max(period,1) cycles; clr restarts the count and masks tick.
module chu_tick_gen #(
    parameter int PW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic [PW-1:0] period,
    output logic          tick
);

    logic [PW-1:0] r_cnt;
    logic [PW-1:0] w_limit;

    // >= rather than == so a shortened period never has to wait for the counter to wrap
    assign w_limit = (period == '0) ? '0 : period - PW'(1);
    assign tick    = ~clr & (r_cnt >= w_limit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clr || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PW'(1);
        end
    end

endmodule

// File: rtl/chu_chasing_led_core.sv
// FPro MMIO slot core driving a one-hot chasing LED that bounces or wraps at a programmable rate.
// Define CHASE_IRQ_EN to add the sweep_done flag, the IRQ register and the irq port.
module chu_chasing_led_core
    import chu_chasing_led_pkg::*;
#(
    parameter int N_LED = 16,
    parameter int PW    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             read,
    input  logic             write,
    input  logic [4:0]       addr,
    input  logic [31:0]      wr_data,
    output logic [31:0]      rd_data,
    output logic [N_LED-1:0] led
`ifdef CHASE_IRQ_EN
    ,
    output logic             irq
`endif
);

    localparam int                POS_W   = $clog2(N_LED);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LED - 1);

    logic             w_wr_en, w_ctrl_wr, w_period_wr, w_clr, w_en_nx;
    logic             w_presc_clr, w_tick, w_step, w_running, w_sweep_hit;
    logic [POS_W-1:0] w_pos_step;
    logic             w_dir_step;

    logic             r_en, r_wrap, r_dir;
    logic [PW-1:0]    r_period;
    logic [31:0]      r_steps;
    logic [POS_W-1:0] r_pos;
    state_t           r_state;

    assign w_wr_en     = cs & write;
    assign w_ctrl_wr   = w_wr_en & (addr == REG_CTRL);
    assign w_period_wr = w_wr_en & (addr == REG_PERIOD);
    assign w_clr       = w_ctrl_wr & wr_data[CTRL_CLR];
    assign w_en_nx     = w_ctrl_wr ? wr_data[CTRL_EN] : r_en;
    assign w_running   = (r_state != IDLE);
    assign w_presc_clr = ~w_running | w_period_wr | w_clr;
    assign w_step      = w_tick & w_en_nx;

    chu_tick_gen #(.PW(PW)) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .clr    (w_presc_clr),
        .period (r_period),
        .tick   (w_tick)
    );

    always_comb begin
        w_pos_step = r_pos;
        w_dir_step = r_dir;
        if (r_state == RUN_UP) begin
            if (r_pos != POS_MAX) begin
                w_pos_step = r_pos + POS_W'(1);
            end else if (r_wrap) begin
                w_pos_step = '0;
            end else begin
                w_pos_step = POS_W'(N_LED - 2);
                w_dir_step = 1'b1;
            end
        end else begin
            if (r_wrap) begin
                w_dir_step = 1'b0;
                w_pos_step = (r_pos == POS_MAX) ? '0 : r_pos + POS_W'(1);
            end else if (r_pos != '0) begin
                w_pos_step = r_pos - POS_W'(1);
            end else begin
                w_pos_step = POS_W'(1);
                w_dir_step = 1'b0;
            end
        end
    end

    assign w_sweep_hit = ((r_state == RUN_UP)   && (w_pos_step == POS_MAX)) ||
                         ((r_state == RUN_DOWN) && (w_pos_step == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_en     <= 1'b0;
            r_wrap   <= 1'b0;
            r_period <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_en   <= wr_data[CTRL_EN];
                r_wrap <= wr_data[CTRL_WRAP];
            end
            if (w_period_wr) begin
                r_period <= wr_data[PW-1:0];
            end
        end
    end

    // clr outranks both the en gate and any tick due in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_pos   <= '0;
            r_dir   <= 1'b0;
            r_steps <= '0;
        end else if (w_clr) begin
            r_pos   <= '0;
            r_dir   <= 1'b0;
            r_steps <= '0;
            r_state <= w_en_nx ? RUN_UP : IDLE;
        end else if (!w_en_nx) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: r_state <= r_dir ? RUN_DOWN : RUN_UP;
                RUN_UP, RUN_DOWN: begin
                    if (w_tick) begin
                        r_steps <= r_steps + 32'd1;
                        r_pos   <= w_pos_step;
                        r_dir   <= w_dir_step;
                        r_state <= w_dir_step ? RUN_DOWN : RUN_UP;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef CHASE_IRQ_EN
    logic r_sweep;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sweep <= 1'b0;
        end else if (w_step && w_sweep_hit) begin
            r_sweep <= 1'b1;
        end else if (w_wr_en && (addr == REG_IRQ) && wr_data[0]) begin
            r_sweep <= 1'b0;
        end
    end

    assign irq = r_sweep;
`endif

    assign led = w_running ? (N_LED'(1) << r_pos) : '0;

    always_comb begin
        rd_data = '0;
        case (addr)
            REG_CTRL: begin
                rd_data[CTRL_EN]   = r_en;
                rd_data[CTRL_WRAP] = r_wrap;
            end
            REG_PERIOD: rd_data[PW-1:0] = r_period;
            REG_STEPS:  rd_data = r_steps;
            REG_STAT: begin
                rd_data[4:0] = 5'(r_pos);
                rd_data[8]   = r_dir;
                rd_data[9]   = w_running;
            end
`ifdef CHASE_IRQ_EN
            REG_IRQ: rd_data[0] = r_sweep;
`endif
            default: rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_chu_chasing_led_core.sv
// Self-checking bench for chu_chasing_led_core (N_LED=4): directed vector table, reset/IRQ sequences,
// then randomized bus traffic compared against a behavioural model of the chaser.
module tb_chu_chasing_led_core;
    import chu_chasing_led_pkg::*;

    localparam int N = 4;

    logic        clk, reset, cs, read, write;
    logic [4:0]  addr;
    logic [31:0] wr_data, rd_data;
    logic [N-1:0] led;
`ifdef CHASE_IRQ_EN
    logic        irq;
`endif

    int checks   = 0;
    int failures = 0;

    chu_chasing_led_core #(.N_LED(N), .PW(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .led     (led)
`ifdef CHASE_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        doWr;
        logic [4:0]  wAddr;
        logic [31:0] wData;
        int          idle;
        logic [3:0]  expLed;
        logic        doRd;
        logic [4:0]  rAddr;
        logic [31:0] expRd;
    } vec_t;

    vec_t tbl[27];

    // Behavioural model: position/direction in plain integers, countdown to the next step
    int          mPos, mLeft;
    bit          mDown, mRun, mEn, mWrap, mSweep;
    logic [31:0] mPeriod, mSteps;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%h expected=0x%h", name, act, exp);
        end
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(posedge clk);
        #1;
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic readCheck(input string name, input logic [4:0] a, input logic [31:0] exp);
        cs = 1'b1; read = 1'b1; addr = a;
        #1;
        checkVal(name, rd_data, exp);
        cs = 1'b0; read = 1'b0;
    endtask

    function automatic int perCycles(input logic [31:0] p);
        return (p == 32'd0) ? 1 : int'(p);
    endfunction

    task automatic modelReset();
        mPos = 0; mDown = 0; mRun = 0; mEn = 0; mWrap = 0; mSweep = 0;
        mPeriod = '0; mSteps = '0; mLeft = 1;
    endtask

    task automatic modelEdge(input logic wr, input logic [4:0] a, input logic [31:0] d);
        bit ctrlW, perW, irqW, enN, clr, stepNow, wasDown, setSweep;
        ctrlW = wr && (a == REG_CTRL);
        perW  = wr && (a == REG_PERIOD);
        irqW  = wr && (a == REG_IRQ);
        enN   = ctrlW ? d[0] : mEn;
        clr   = ctrlW && d[2];
        stepNow  = mRun && enN && !clr && !perW && (mLeft == 1);
        setSweep = 0;
        if (stepNow) begin
            wasDown = mDown;
            mSteps  = mSteps + 32'd1;
            if (!mDown) begin
                if (mPos < N - 1)  mPos = mPos + 1;
                else if (mWrap)    mPos = 0;
                else begin mDown = 1; mPos = N - 2; end
            end else begin
                if (mWrap) begin mDown = 0; mPos = (mPos == N - 1) ? 0 : mPos + 1; end
                else if (mPos > 0) mPos = mPos - 1;
                else begin mDown = 0; mPos = 1; end
            end
            setSweep = (!wasDown && mPos == N - 1) || (wasDown && mPos == 0);
        end
        if (!mRun || perW || clr) mLeft = perCycles(perW ? d : mPeriod);
        else if (stepNow)          mLeft = perCycles(mPeriod);
        else if (mLeft > 1)        mLeft = mLeft - 1;
        if (clr) begin mPos = 0; mDown = 0; mSteps = '0; end
        if (ctrlW) begin mEn = d[0]; mWrap = d[1]; end
        if (perW) mPeriod = d;
        mRun = enN;
        if (setSweep)              mSweep = 1;
        else if (irqW && d[0])     mSweep = 0;
    endtask

    function automatic logic [31:0] modelRead(input logic [4:0] a);
        case (a)
            REG_CTRL:   return {30'd0, mWrap, mEn};
            REG_PERIOD: return mPeriod;
            REG_STEPS:  return mSteps;
            REG_STAT:   return {22'd0, mRun, mDown, 3'd0, 5'(mPos)};
`ifdef CHASE_IRQ_EN
            REG_IRQ:    return {31'd0, mSweep};
`endif
            default:    return 32'd0;
        endcase
    endfunction

    task automatic doCycle(input logic iCs, input logic iWr, input logic [4:0] a, input logic [31:0] d);
        logic [4:0] ra;
        cs = iCs; write = iWr; addr = a; wr_data = d;
        @(posedge clk);
        modelEdge(iCs && iWr, a, d);
        #1;
        cs = 1'b0; write = 1'b0;
        checkVal("rnd_led", 32'(led), mRun ? (32'd1 << mPos) : 32'd0);
`ifdef CHASE_IRQ_EN
        checkVal("rnd_irq", 32'(irq), 32'(mSweep));
`endif
        ra = 5'($urandom_range(0, 7));
        readCheck($sformatf("rnd_rd_addr%0d", ra), ra, modelRead(ra));
    endtask

    task automatic applyReset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        modelReset();
    endtask

    initial begin
        cs = 0; read = 0; write = 0; addr = '0; wr_data = '0;
        applyReset();

        // Reset state: outputs idle and every register reads zero
        checkVal("reset_led", 32'(led), 32'd0);
`ifdef CHASE_IRQ_EN
        checkVal("reset_irq", 32'(irq), 32'd0);
`endif
        for (int a = 0; a <= 4; a++) readCheck($sformatf("reset_rd%0d", a), 5'(a), 32'd0);
        readCheck("unmapped_rd7", 5'd7, 32'd0);

        // Bounce at PERIOD=3, wrap at PERIOD=1, PERIOD shortened mid-count, clr against a due tick
        tbl[0]  = '{1'b1, REG_PERIOD, 32'd3,   0, 4'h0, 1'b1, REG_PERIOD, 32'd3};
        tbl[1]  = '{1'b1, REG_CTRL,   32'd1,   0, 4'h1, 1'b1, REG_STAT,   32'h200};
        tbl[2]  = '{1'b0, REG_CTRL,   32'd0,   3, 4'h2, 1'b0, REG_CTRL,   32'd0};
        tbl[3]  = '{1'b0, REG_CTRL,   32'd0,   3, 4'h4, 1'b0, REG_CTRL,   32'd0};
        tbl[4]  = '{1'b0, REG_CTRL,   32'd0,   3, 4'h8, 1'b0, REG_CTRL,   32'd0};
        tbl[5]  = '{1'b0, REG_CTRL,   32'd0,   3, 4'h4, 1'b1, REG_STAT,   32'h302};
        tbl[6]  = '{1'b0, REG_CTRL,   32'd0,   3, 4'h2, 1'b0, REG_CTRL,   32'd0};
        tbl[7]  = '{1'b0, REG_CTRL,   32'd0,   3, 4'h1, 1'b0, REG_CTRL,   32'd0};
        tbl[8]  = '{1'b0, REG_CTRL,   32'd0,   3, 4'h2, 1'b0, REG_CTRL,   32'd0};
        tbl[9]  = '{1'b0, REG_CTRL,   32'd0,   0, 4'h2, 1'b1, REG_STEPS,  32'd7};
        tbl[10] = '{1'b1, REG_CTRL,   32'd4,   0, 4'h0, 1'b1, REG_STEPS,  32'd0};
        tbl[11] = '{1'b1, REG_PERIOD, 32'd1,   0, 4'h0, 1'b1, REG_CTRL,   32'd0};
        tbl[12] = '{1'b1, REG_CTRL,   32'd3,   0, 4'h1, 1'b1, REG_CTRL,   32'd3};
        tbl[13] = '{1'b0, REG_CTRL,   32'd0,   1, 4'h2, 1'b0, REG_CTRL,   32'd0};
        tbl[14] = '{1'b0, REG_CTRL,   32'd0,   1, 4'h4, 1'b0, REG_CTRL,   32'd0};
        tbl[15] = '{1'b0, REG_CTRL,   32'd0,   1, 4'h8, 1'b0, REG_CTRL,   32'd0};
        tbl[16] = '{1'b0, REG_CTRL,   32'd0,   1, 4'h1, 1'b0, REG_CTRL,   32'd0};
        tbl[17] = '{1'b1, REG_CTRL,   32'd4,   0, 4'h0, 1'b0, REG_CTRL,   32'd0};
        tbl[18] = '{1'b1, REG_PERIOD, 32'd100, 0, 4'h0, 1'b0, REG_CTRL,   32'd0};
        tbl[19] = '{1'b1, REG_CTRL,   32'd1,   0, 4'h1, 1'b0, REG_CTRL,   32'd0};
        tbl[20] = '{1'b0, REG_CTRL,   32'd0,  50, 4'h1, 1'b0, REG_CTRL,   32'd0};
        tbl[21] = '{1'b1, REG_PERIOD, 32'd10,  9, 4'h1, 1'b0, REG_CTRL,   32'd0};
        tbl[22] = '{1'b0, REG_CTRL,   32'd0,   1, 4'h2, 1'b1, REG_STEPS,  32'd1};
        tbl[23] = '{1'b0, REG_CTRL,   32'd0,   9, 4'h2, 1'b0, REG_CTRL,   32'd0};
        tbl[24] = '{1'b1, REG_CTRL,   32'd5,   0, 4'h1, 1'b1, REG_STEPS,  32'd0};
        tbl[25] = '{1'b0, REG_CTRL,   32'd0,   0, 4'h1, 1'b1, REG_STAT,   32'h200};
        tbl[26] = '{1'b0, REG_CTRL,   32'd0,  10, 4'h2, 1'b1, REG_STEPS,  32'd1};

        for (int i = 0; i < 27; i++) begin
            if (tbl[i].doWr) busWrite(tbl[i].wAddr, tbl[i].wData);
            repeat (tbl[i].idle) idleCycle();
            checkVal($sformatf("vec%0d_led", i), 32'(led), 32'(tbl[i].expLed));
            if (tbl[i].doRd) readCheck($sformatf("vec%0d_rd", i), tbl[i].rAddr, tbl[i].expRd);
        end

        // Asynchronous reset pulse mid-run, away from any clock edge
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        checkVal("midreset_led", 32'(led), 32'd0);
        for (int a = 0; a <= 3; a++) readCheck($sformatf("midreset_rd%0d", a), 5'(a), 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        idleCycle();
        checkVal("postreset_led", 32'(led), 32'd0);

`ifdef CHASE_IRQ_EN
        busWrite(REG_PERIOD, 32'd1);
        busWrite(REG_CTRL, 32'd1);
        idleCycle();
        idleCycle();
        checkVal("irq_before_sweep", 32'(irq), 32'd0);
        idleCycle();
        checkVal("irq_at_sweep", 32'(irq), 32'd1);
        readCheck("irq_reg_set", REG_IRQ, 32'd1);
        busWrite(REG_IRQ, 32'd1);
        checkVal("irq_after_w1c", 32'(irq), 32'd0);
        busWrite(REG_CTRL, 32'd0);
`endif

        // Randomized traffic against the model
        applyReset();
        for (int c = 0; c < 1500; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 55) begin
                doCycle(1'b0, 1'b0, 5'(REG_CTRL), 32'd0);
            end else if (r < 70) begin
                logic [31:0] d;
                d = {$urandom} & 32'hFFFF_FFF8;
                d[0] = ($urandom_range(0, 99) < 85);
                d[1] = 1'($urandom);
                d[2] = ($urandom_range(0, 99) < 10);
                doCycle(1'b1, 1'b1, REG_CTRL, d);
            end else if (r < 82) begin
                doCycle(1'b1, 1'b1, REG_PERIOD, 32'($urandom_range(0, 4)));
            end else if (r < 88) begin
                doCycle(1'b1, 1'b1, REG_IRQ, 32'($urandom_range(0, 1)));
            end else if (r < 94) begin
                logic [4:0] ua;
                ua = ($urandom_range(0, 1) == 0) ? 5'(2 + $urandom_range(0, 1)) : 5'($urandom_range(5, 31));
                doCycle(1'b1, 1'b1, ua, $urandom);
            end else begin
                doCycle(1'b0, 1'b1, 5'($urandom_range(0, 1)), $urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
